// File: rtl/snake_pkg.sv
// Shared constants for the snake game front end: playfield size, button indices, LFSR seed.
package snake_pkg;

    localparam int unsigned GRID_WIDTH  = 40;
    localparam int unsigned GRID_HEIGHT = 30;
    localparam int unsigned XW          = $clog2(GRID_WIDTH);
    localparam int unsigned YW          = $clog2(GRID_HEIGHT);

    localparam int unsigned NUM_BTN    = 5;
    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_RIGHT  = 1;
    localparam int unsigned BTN_UP     = 2;
    localparam int unsigned BTN_DOWN   = 3;
    localparam int unsigned BTN_CENTER = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Counter width able to hold 0..n-1; at least one bit so n == 1 still gets a register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-FF synchronizer, stability counter clocked by the tick enable, and a
// pending flag that turns a debounced rising edge into a single tick-aligned press pulse.
module button_debounce
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 250_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic tick_i,
    output logic pressed_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        if (tick_i) begin
            // The pulse for a pending press goes out on this tick, so drop the flag now.
            if (pend_q) begin
                pend_d = 1'b0;
            end
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                stable_d = sync2_q;
                cnt_d    = '0;
                if (sync2_q) begin
                    pend_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed_o = pend_q & tick_i;

endmodule

// File: rtl/snake_timebase_io.sv
// Single-clock front end for the snake game: tick/game/segment strobes, debounced button
// press pulses and in-range pseudo-random food coordinates.
module snake_timebase_io
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 4,
    parameter int unsigned GAME_TICKS     = 2_500_000,
    parameter int unsigned SEG_DIV        = 100_000,
    parameter int unsigned DEBOUNCE_TICKS = 250_000
) (
    input  logic               MasterClock,
    input  logic               ResetN,
    input  logic [NUM_BTN-1:0] Buttons,
    output logic               TickEn,
    output logic               GameTick,
    output logic               SegTick,
    output logic [NUM_BTN-1:0] Pressed,
    output logic [XW-1:0]      FoodX,
    output logic [YW-1:0]      FoodY
);

    localparam int unsigned TW = cnt_width(TICK_DIV);
    localparam int unsigned GW = cnt_width(GAME_TICKS);
    localparam int unsigned SW = cnt_width(SEG_DIV);

    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GameLast = GW'(GAME_TICKS - 1);
    localparam logic [SW-1:0] SegLast  = SW'(SEG_DIV - 1);
    localparam logic [XW-1:0] GridW    = XW'(GRID_WIDTH);
    localparam logic [YW-1:0] GridH    = YW'(GRID_HEIGHT);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [GW-1:0] game_cnt_q, game_cnt_d;
    logic [SW-1:0] seg_cnt_q, seg_cnt_d;
    logic          tick_q, tick_d;
    logic          game_q, game_d;
    logic          seg_q, seg_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          lfsr_fb;
    logic [XW-1:0] x_raw, food_x_q, food_x_d;
    logic [YW-1:0] y_raw, food_y_q, food_y_d;

    // Strobes are registered from the next-state counters so they line up with the counter
    // reaching its last value and read 0 straight out of reset.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
        tick_d     = (tick_cnt_d == TickLast);

        game_cnt_d = game_cnt_q;
        if (tick_q) begin
            game_cnt_d = (game_cnt_q == GameLast) ? '0 : game_cnt_q + 1'b1;
        end
        game_d = tick_d && (game_cnt_d == GameLast);

        seg_cnt_d = (seg_cnt_q == SegLast) ? '0 : seg_cnt_q + 1'b1;
        seg_d     = (seg_cnt_d == SegLast);
    end

    // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = (lfsr_q == '0) ? LFSR_SEED : {lfsr_fb, lfsr_q[15:1]};

        x_raw    = lfsr_q[XW-1:0];
        y_raw    = lfsr_q[15 -: YW];
        food_x_d = (x_raw >= GridW) ? x_raw - GridW : x_raw;
        food_y_d = (y_raw >= GridH) ? y_raw - GridH : y_raw;
    end

    always_ff @(posedge MasterClock or negedge ResetN) begin
        if (!ResetN) begin
            tick_cnt_q <= '0;
            game_cnt_q <= '0;
            seg_cnt_q  <= '0;
            tick_q     <= 1'b0;
            game_q     <= 1'b0;
            seg_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            food_x_q   <= '0;
            food_y_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            game_cnt_q <= game_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            tick_q     <= tick_d;
            game_q     <= game_d;
            seg_q      <= seg_d;
            lfsr_q     <= lfsr_d;
            food_x_q   <= food_x_d;
            food_y_q   <= food_y_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .clk_i    (MasterClock),
            .rst_ni   (ResetN),
            .btn_i    (Buttons[i]),
            .tick_i   (tick_q),
            .pressed_o(Pressed[i])
        );
    end

    assign TickEn   = tick_q;
    assign GameTick = game_q;
    assign SegTick  = seg_q;
    assign FoodX    = food_x_q;
    assign FoodY    = food_y_q;

endmodule

// File: tb/tb_snake_timebase_io.sv
// Directed bench for snake_timebase_io with shortened dividers (4/5/10/3).
module tb_snake_timebase_io;
    import snake_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_BTN-1:0] buttons = '0;
    logic               tick_en, game_tick, seg_tick;
    logic [NUM_BTN-1:0] pressed;
    logic [XW-1:0]      food_x;
    logic [YW-1:0]      food_y;

    int checks = 0;
    int failures = 0;

    snake_timebase_io #(
        .TICK_DIV      (4),
        .GAME_TICKS    (5),
        .SEG_DIV       (10),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .MasterClock(clk),
        .ResetN     (rst_n),
        .Buttons    (buttons),
        .TickEn     (tick_en),
        .GameTick   (game_tick),
        .SegTick    (seg_tick),
        .Pressed    (pressed),
        .FoodX      (food_x),
        .FoodY      (food_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drops into reset at a negedge, checks outputs clear immediately, then releases.
    // Returns at the sampling point of cycle 1 (before the first edge after release).
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        buttons = '0;
        #1;
        check("reset_outputs", {tick_en, game_tick, seg_tick, pressed, food_x, food_y}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle k is sampled just before the k-th rising edge after reset release.
    task automatic run_phase(input int n, input logic [NUM_BTN-1:0] btn, input int btn_off,
                             input int press_at, input logic [NUM_BTN-1:0] press_exp);
        for (int k = 1; k <= n; k++) begin
            if (k == 1) buttons = btn;
            if (k == btn_off) buttons = '0;
            check("tick_en", tick_en, (k % 4 == 0));
            check("game_tick", game_tick, (k % 20 == 0));
            check("seg_tick", seg_tick, (k % 10 == 0));
            check("pressed", pressed, (k == press_at) ? press_exp : 5'd0);
            check("food_x_range", food_x < 6'd40, 1'b1);
            check("food_y_range", food_y < 5'd30, 1'b1);
            if (k == 1) check("food_reset", {food_x, food_y}, 32'd0);
            if (k == 2) begin
                check("food_x_seed", food_x, 6'd33);
                check("food_y_seed", food_y, 5'd21);
            end
            if (k == 3) begin
                check("food_x_step1", food_x, 6'd8);
                check("food_y_step1", food_y, 5'd10);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] m;
        logic [5:0]  ex;
        logic [4:0]  ey;

        // Free-running strobes, nothing pressed.
        do_reset();
        run_phase(100, 5'b00000, 0, 0, 5'b00000);

        // Left held 40 cycles: one pulse on the 4th TickEn, none on release.
        do_reset();
        run_phase(80, 5'b00001, 41, 16, 5'b00001);

        // Up high for only 2 TickEns: filtered out.
        do_reset();
        run_phase(40, 5'b00100, 9, 0, 5'b00000);

        // Right and Center together pulse in the same cycle.
        do_reset();
        run_phase(40, 5'b10010, 0, 16, 5'b10010);

        // Reset during the pulse cycle with pending set: cleared at once, no pulse later.
        do_reset();
        run_phase(14, 5'b01000, 0, 0, 5'b00000);
        do_reset();
        run_phase(40, 5'b00000, 0, 0, 5'b00000);

        // Reset while the stability count is mid-way.
        do_reset();
        run_phase(10, 5'b01000, 0, 0, 5'b00000);
        do_reset();
        run_phase(40, 5'b00000, 0, 0, 5'b00000);

        // Food coordinates against a reference LFSR over more than one full period.
        do_reset();
        m = 16'hACE1;
        for (int t = 1; t <= 70000; t++) begin
            if (t >= 2) begin
                ex = m[5:0];
                ey = m[15:11];
                if (ex >= 6'd40) ex = ex - 6'd40;
                if (ey >= 5'd30) ey = ey - 5'd30;
                check("food_x_model", food_x, ex);
                check("food_y_model", food_y, ey);
                m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
            end
            check("food_x_range", food_x < 6'd40, 1'b1);
            check("food_y_range", food_y < 5'd30, 1'b1);
            // One full period after the seed value appears, it must appear again.
            if (t == 65537) begin
                check("food_x_period", food_x, 6'd33);
                check("food_y_period", food_y, 5'd21);
            end
            @(negedge clk);
        end

        // Seed restored by a fresh reset.
        do_reset();
        run_phase(3, 5'b00000, 0, 0, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
